if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
- Instruction-fetch stage; sits directly upstream of the decode stage and feeds it.
- Owns the PC and drives a req/ack instruction-memory port. The memory may answer in the same cycle or after N wait cycles.
- Presents {if_pc, if_instruction, if_valid} to decode. Holds that output under hazard freeze. Redirects and flushes on a taken branch from EXE.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset.
- PC_INC, 4, byte increment per sequential fetch.
- NOP_INSTR, 32'h0000_0000, instruction word driven when the output is flushed or empty.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- freeze  in  1  hazard stall from decode: hold the output register.
- branch_taken  in  1  one-cycle redirect pulse from EXE.
- branch_addr  in  32  redirect target, valid with branch_taken.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; registered.
- imem_ack  in  1  read data valid; may be high in the same cycle as imem_req.
- imem_rdata  in  32  instruction word, valid with imem_ack.
- if_pc  out  32  fetched address + PC_INC.
- if_instruction  out  32  fetched word.
- if_valid  out  1  if_pc/if_instruction hold a real instruction.

Behaviour:
- Reset (rst=1 at edge):
  - fetch_pc=RESET_PC, imem_addr=RESET_PC, state=FETCH, skid empty.
  - if_valid=0, if_instruction=NOP_INSTR, if_pc=0.
  - imem_req=0 while rst=1; asserted from the first cycle after rst drops.
  - Reset mid-request abandons the request. A late ack is ignored until the next FETCH request.
- Handshake:
  - imem_addr must stay stable while imem_req=1 and imem_ack=0.
  - A transfer completes on any cycle with imem_req&imem_ack.
  - Zero-wait memory gives one instruction per cycle.
- Output register load: loads when (!freeze || !if_valid).
  - Load from skid if skid full, else from the completing transfer.
  - A load with nothing available sets if_valid=0 and if_instruction=NOP_INSTR.
- FSM (imem_req=1 in FETCH and DRAIN, 0 in FULL):
  - FETCH, ack, no branch, output loadable: output<=rdata, if_pc<=imem_addr+PC_INC, fetch_pc and imem_addr += PC_INC; stay FETCH.
  - FETCH, ack, no branch, output not loadable (freeze&&if_valid): rdata and PC into skid, fetch_pc += PC_INC; go FULL.
  - FETCH, no ack: hold address; stay FETCH.
  - FULL, freeze released: skid moves to output, skid empties, imem_addr<=fetch_pc; go FETCH (request issued next cycle).
  - FULL, freeze held: stay FULL.
  - DRAIN: keep the stale address. On ack, discard data, imem_addr<=fetch_pc; go FETCH.
- Branch (branch_taken=1), priority over freeze and over ack data:
  - fetch_pc<=branch_addr; output flushed (if_valid=0, NOP_INSTR); skid cleared.
  - FETCH with ack, or FULL: imem_addr<=branch_addr; go FETCH.
  - FETCH without ack: go DRAIN (outstanding request must complete).
  - DRAIN: target updated to newest branch_addr; stays DRAIN unless ack this cycle, in which case go FETCH at the newest target.
- Arithmetic: PC wraps modulo 2^32; 32'hFFFF_FFFC + 4 = 0. No alignment check.
- No combinational path from imem_rdata to if_* outputs. All outputs are registered.

Optional Feature:
- Macro: IF_STALL_CNT_EN.
- Defined:
  - Adds output port stall_cycles (out, 32).
  - Increments once per cycle when (imem_req&&!imem_ack) || (freeze&&if_valid).
  - Cleared by rst; wraps at 2^32.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Zero-wait stream: ack tied to req, RESET_PC=0, words 0x11,0x22,0x33 -> if_valid=1 from cycle 2 after reset, if_pc=4,8,12, instructions in order, one per cycle.
- 2-wait memory: ack every 3rd cycle -> imem_addr stable across wait cycles; if_valid=1 exactly once per 3 cycles; no duplicated or skipped PCs.
- Freeze with in-flight fetch: freeze=1 for 4 cycles while output holds PC 8 and ack returns word at PC 8 -> FULL, imem_req=0. After release, if_pc goes 8 -> 12 -> 16 with no loss.
- Branch during wait: branch_taken=1, branch_addr=0x100 while a request at 0x20 is unacked -> DRAIN. The 0x20 data is discarded and if_valid=0. The next request is at 0x100, and if_pc=0x104 after its ack.
- Branch with freeze and full skid: freeze=1, skid full, branch to 0x40 -> skid cleared, if_valid=0 the next cycle, next imem_addr=0x40.
- Wrap plus reset mid-request: RESET_PC=0xFFFF_FFFC -> second fetch at 0x0. Assert rst mid-request -> all outputs back to reset values the next cycle. stall_cycles=0 when IF_STALL_CNT_EN is defined.

Source files
------------

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: PC owner and req/ack instruction fetch feeding decode, with skid buffer and branch redirect
// Optional feature: define IF_STALL_CNT_EN to add the stall_cycles counter output.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] PC_INC    = 32'd4,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_pc,
    output logic [31:0] if_instruction,
    output logic        if_valid
`ifdef IF_STALL_CNT_EN
    ,
    output logic [31:0] stall_cycles
`endif
);

    typedef enum logic [1:0] {FETCH, FULL, DRAIN} state_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] addr_q, addr_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic        load;
    logic [31:0] next_pc;

    assign load    = !freeze || !out_valid_q;
    assign next_pc = fetch_pc_q + PC_INC;

    // State and datapath registers; reset abandons any outstanding request
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FETCH;
            fetch_pc_q   <= RESET_PC;
            addr_q       <= RESET_PC;
            skid_valid_q <= 1'b0;
            skid_pc_q    <= 32'd0;
            skid_instr_q <= NOP_INSTR;
            out_valid_q  <= 1'b0;
            out_pc_q     <= 32'd0;
            out_instr_q  <= NOP_INSTR;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            addr_q       <= addr_d;
            skid_valid_q <= skid_valid_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
            out_valid_q  <= out_valid_d;
            out_pc_q     <= out_pc_d;
            out_instr_q  <= out_instr_d;
        end
    end

    // Next state: a branch with an unacked request must drain it before refetching
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH: begin
                if (branch_taken) state_d = imem_ack ? FETCH : DRAIN;
                else if (imem_ack && !load) state_d = FULL;
            end
            FULL:    state_d = (branch_taken || load) ? FETCH : FULL;
            DRAIN:   state_d = imem_ack ? FETCH : DRAIN;
            default: state_d = FETCH;
        endcase
    end

    // Datapath: PC advance, skid capture/release and output register loading
    always_comb begin
        fetch_pc_d   = fetch_pc_q;
        addr_d       = addr_q;
        skid_valid_d = skid_valid_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        out_valid_d  = out_valid_q;
        out_pc_d     = out_pc_q;
        out_instr_d  = out_instr_q;
        if (branch_taken) begin
            fetch_pc_d   = branch_addr;
            skid_valid_d = 1'b0;
            out_valid_d  = 1'b0;
            out_instr_d  = NOP_INSTR;
            if (state_q == FULL || imem_ack) addr_d = branch_addr;
        end else begin
            case (state_q)
                FETCH: begin
                    if (imem_ack) begin
                        fetch_pc_d = next_pc;
                        if (load) begin
                            addr_d      = next_pc;
                            out_valid_d = 1'b1;
                            out_pc_d    = next_pc;
                            out_instr_d = imem_rdata;
                        end else begin
                            skid_valid_d = 1'b1;
                            skid_pc_d    = next_pc;
                            skid_instr_d = imem_rdata;
                        end
                    end else if (load) begin
                        out_valid_d = 1'b0;
                        out_instr_d = NOP_INSTR;
                    end
                end
                FULL: begin
                    if (load) begin
                        out_valid_d  = skid_valid_q;
                        out_pc_d     = skid_pc_q;
                        out_instr_d  = skid_instr_q;
                        skid_valid_d = 1'b0;
                        addr_d       = fetch_pc_q;
                    end
                end
                DRAIN: begin
                    if (imem_ack) addr_d = fetch_pc_q;
                    if (load) begin
                        out_valid_d = 1'b0;
                        out_instr_d = NOP_INSTR;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs: request is suppressed while reset is held and while the skid is full
    always_comb begin
        imem_req       = !rst && (state_q != FULL);
        imem_addr      = addr_q;
        if_pc          = out_pc_q;
        if_instruction = out_instr_q;
        if_valid       = out_valid_q;
    end

`ifdef IF_STALL_CNT_EN
    logic [31:0] stall_q, stall_d;

    // Stall counter: memory wait cycles plus cycles the output is held by freeze
    always_comb stall_d = stall_q + 32'((imem_req && !imem_ack) || (freeze && out_valid_q));

    // Stall counter register
    always_ff @(posedge clk) stall_q <= rst ? 32'd0 : stall_d;

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed checks of streaming, wait states, freeze/skid, branches, wrap and reset
module tb_if_fetch_stage;
    logic        clk;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] if_pc;
    logic [31:0] if_instruction;
    logic        if_valid;
    logic        ack_auto;
    logic        ack_man;
    int          n_cmp;
    int          n_bad;
`ifdef IF_STALL_CNT_EN
    logic [31:0] stall_cycles;
`endif

    if_fetch_stage dut (
        .clk(clk),
        .rst(rst),
        .freeze(freeze),
        .branch_taken(branch_taken),
        .branch_addr(branch_addr),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ack(imem_ack),
        .imem_rdata(imem_rdata),
        .if_pc(if_pc),
        .if_instruction(if_instruction),
        .if_valid(if_valid)
`ifdef IF_STALL_CNT_EN
        ,
        .stall_cycles(stall_cycles)
`endif
    );

    // memory: word at address a is ((a>>2)+1)*0x11 -> 0x11, 0x22, 0x33 ...
    assign imem_ack   = ack_auto ? imem_req : ack_man;
    assign imem_rdata = ((imem_addr >> 2) + 32'd1) * 32'h11;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        freeze = 1'b0;
        branch_taken = 1'b0;
        branch_addr = 32'd0;
        ack_auto = 1'b1;
        ack_man = 1'b0;
        step();
        step();
        chk("rst_valid", if_valid, 0);
        chk("rst_instr", if_instruction, 32'h0);
        chk("rst_pc", if_pc, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_req", imem_req, 0);
`ifdef IF_STALL_CNT_EN
        chk("rst_stall", stall_cycles, 32'd0);
`endif
        rst = 1'b0;
        #1;
        chk("req_after_rst", imem_req, 1);
        // zero-wait stream
        step();
        chk("zw0_valid", if_valid, 1);
        chk("zw0_pc", if_pc, 32'd4);
        chk("zw0_instr", if_instruction, 32'h11);
        step();
        chk("zw1_pc", if_pc, 32'd8);
        chk("zw1_instr", if_instruction, 32'h22);
        step();
        chk("zw2_pc", if_pc, 32'd12);
        chk("zw2_instr", if_instruction, 32'h33);
        chk("zw2_addr", imem_addr, 32'd12);
        // freeze with in-flight fetch -> skid full, no request
        freeze = 1'b1;
        step();
        chk("frz_req", imem_req, 0);
        chk("frz_pc", if_pc, 32'd12);
        chk("frz_addr", imem_addr, 32'd12);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("frz_hold_pc", if_pc, 32'd12);
            chk("frz_hold_req", imem_req, 0);
        end
        freeze = 1'b0;
        step();
        chk("unfrz_pc", if_pc, 32'd16);
        chk("unfrz_instr", if_instruction, 32'h44);
        chk("unfrz_addr", imem_addr, 32'd16);
        chk("unfrz_req", imem_req, 1);
        step();
        chk("unfrz2_pc", if_pc, 32'd20);
        chk("unfrz2_instr", if_instruction, 32'h55);
        // 2-wait memory: ack every third cycle
        ack_auto = 1'b0;
        ack_man = 1'b0;
        for (int k = 0; k < 2; k++) begin
            for (int w = 0; w < 2; w++) begin
                step();
                chk("wait_valid", if_valid, 0);
                chk("wait_addr", imem_addr, 32'd20 + 32'(4 * k));
            end
            ack_man = 1'b1;
            step();
            ack_man = 1'b0;
            chk("ack_valid", if_valid, 1);
            chk("ack_pc", if_pc, 32'd24 + 32'(4 * k));
            chk("ack_instr", if_instruction, k == 0 ? 32'h66 : 32'h77);
        end
        // branch while request at 0x1C is unacked -> drain
        branch_taken = 1'b1;
        branch_addr = 32'h100;
        step();
        branch_taken = 1'b0;
        chk("drn_valid", if_valid, 0);
        chk("drn_addr", imem_addr, 32'h1C);
        chk("drn_req", imem_req, 1);
        step();
        chk("drn2_addr", imem_addr, 32'h1C);
        ack_man = 1'b1;
        step();
        chk("drn_done_valid", if_valid, 0);
        chk("drn_done_addr", imem_addr, 32'h100);
        step();
        chk("br_pc", if_pc, 32'h104);
        chk("br_instr", if_instruction, 32'h451);
        chk("br_valid", if_valid, 1);
        ack_man = 1'b0;
        ack_auto = 1'b1;
        // branch while frozen with full skid
        freeze = 1'b1;
        step();
        chk("sk_req", imem_req, 0);
        chk("sk_pc", if_pc, 32'h104);
        branch_taken = 1'b1;
        branch_addr = 32'h40;
        step();
        branch_taken = 1'b0;
        freeze = 1'b0;
        chk("skbr_valid", if_valid, 0);
        chk("skbr_instr", if_instruction, 32'h0);
        chk("skbr_addr", imem_addr, 32'h40);
        chk("skbr_req", imem_req, 1);
        step();
        chk("skbr2_pc", if_pc, 32'h44);
        chk("skbr2_instr", if_instruction, 32'h121);
        // address wrap
        branch_taken = 1'b1;
        branch_addr = 32'hFFFF_FFFC;
        step();
        branch_taken = 1'b0;
        chk("wr_valid", if_valid, 0);
        chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
        step();
        chk("wr_pc", if_pc, 32'h0);
        chk("wr_instr", if_instruction, 32'h4000_0000);
        chk("wr_addr2", imem_addr, 32'h0);
        step();
        chk("wr2_pc", if_pc, 32'h4);
        chk("wr2_instr", if_instruction, 32'h11);
        // reset with a request outstanding
        ack_auto = 1'b0;
        ack_man = 1'b0;
        rst = 1'b1;
        step();
        chk("mr_valid", if_valid, 0);
        chk("mr_instr", if_instruction, 32'h0);
        chk("mr_pc", if_pc, 32'h0);
        chk("mr_addr", imem_addr, 32'h0);
        chk("mr_req", imem_req, 0);
`ifdef IF_STALL_CNT_EN
        chk("mr_stall", stall_cycles, 32'd0);
`endif
        rst = 1'b0;
        ack_auto = 1'b1;
        step();
        chk("mr2_pc", if_pc, 32'h4);
        chk("mr2_instr", if_instruction, 32'h11);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
